// File: rtl/laser_scheduler.sv
// -----------------------------------------------------------------------------
// laser_scheduler
//   Shares the single VGA write port between N_LASERS laser instances. Once per
//   frame it walks the lasers in round-robin order, starting from a pointer
//   that advances by one every frame. Each active laser gets a one-cycle start
//   pulse, then owns the VGA port until it reports done. The destroyed-car masks
//   seen while lasers are being serviced are ORed into one per-frame result.
//
//   Optional feature macro: LASER_SCHED_TIMEOUT_EN
//     Defined   -> a per-service watchdog abandons a laser after TIMEOUT cycles
//                  in BUSY and sets the sticky timeout_err output.
//     Undefined -> no watchdog and no timeout_err port; BUSY waits indefinitely.
//
// Parameters
//   N_LASERS  number of lasers scheduled (1..8)
//   TIMEOUT   watchdog limit in BUSY cycles (exists only with the macro)
//
// Ports
//   clk             in   system clock, rising edge
//   resetn          in   asynchronous active-low reset
//   frame_start     in   1-cycle pulse, starts a frame's service pass (IDLE only)
//   laser_active    in   [N]    laser i is placed and should be serviced
//   laser_done      in   [N]    done pulse from laser i
//   laser_we        in   [N]    per-laser VGA write enable
//   laser_coords    in   [15N]  per-laser {x,y}, laser i at [15i+14:15i]
//   laser_colour    in   [9N]   per-laser colour, laser i at [9i+8:9i]
//   laser_destroyed in   [4N]   per-laser destroyed-car mask, laser i at [4i+3:4i]
//   enable_draw     out  [N]    one-hot 1-cycle start pulse to the selected laser
//   vga_WriteEn     out         write enable of the laser being serviced
//   vga_coords      out  [15]   coords of the laser being serviced
//   vga_colour      out  [9]    colour of the laser being serviced
//   destroyed_cars  out  [4]    OR of the serviced masks, updated with cycle_done
//   cycle_done      out         1-cycle pulse once every laser has been visited
//   busy            out         high whenever the scheduler is not idle
//   frame_overrun   out         sticky: frame_start seen while not idle
//   timeout_err     out         sticky watchdog flag (macro only)
// -----------------------------------------------------------------------------
module laser_scheduler #(
  parameter int N_LASERS = 4
`ifdef LASER_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT  = 4095
`endif
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   frame_start,
  input  logic [N_LASERS-1:0]    laser_active,
  input  logic [N_LASERS-1:0]    laser_done,
  input  logic [N_LASERS-1:0]    laser_we,
  input  logic [15*N_LASERS-1:0] laser_coords,
  input  logic [9*N_LASERS-1:0]  laser_colour,
  input  logic [4*N_LASERS-1:0]  laser_destroyed,
  output logic [N_LASERS-1:0]    enable_draw,
  output logic                   vga_WriteEn,
  output logic [14:0]            vga_coords,
  output logic [8:0]             vga_colour,
  output logic [3:0]             destroyed_cars,
  output logic                   cycle_done,
  output logic                   busy,
  output logic                   frame_overrun
`ifdef LASER_SCHED_TIMEOUT_EN
  ,
  output logic                   timeout_err
`endif
);

  localparam int IDX_W = (N_LASERS > 1) ? $clog2(N_LASERS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_START,
    S_BUSY,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [3:0]          scanned_q;
  logic [3:0]          acc_q;
  logic [N_LASERS-1:0] enable_draw_q;
  logic [3:0]          destroyed_q;
  logic                cycle_done_q;
  logic                overrun_q;

  // Next-value helpers shared by SCAN and BUSY
  logic [IDX_W-1:0]    idx_inc_d;
  logic [IDX_W-1:0]    rr_inc_d;
  logic [3:0]          scanned_inc_d;
  logic                last_d;
  logic                abort_d;

  // Signals of the laser selected by idx_q
  logic [N_LASERS-1:0] idx_oh;
  logic                sel_active;
  logic                sel_done;
  logic                sel_we;
  logic [14:0]         sel_coords;
  logic [8:0]          sel_colour;
  logic [3:0]          sel_destroyed;

  assign idx_inc_d     = (idx_q == IDX_W'(N_LASERS - 1)) ? '0 : idx_q + 1'b1;
  assign rr_inc_d      = (rr_ptr_q == IDX_W'(N_LASERS - 1)) ? '0 : rr_ptr_q + 1'b1;
  assign scanned_inc_d = scanned_q + 4'd1;
  assign last_d        = (scanned_inc_d == 4'(N_LASERS));

  // Select by comparison rather than a variable part-select so that an index
  // can never address bits beyond the packed buses.
  always_comb begin
    idx_oh        = '0;
    sel_active    = 1'b0;
    sel_done      = 1'b0;
    sel_we        = 1'b0;
    sel_coords    = '0;
    sel_colour    = '0;
    sel_destroyed = '0;
    for (int i = 0; i < N_LASERS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        idx_oh[i]     = 1'b1;
        sel_active    = laser_active[i];
        sel_done      = laser_done[i];
        sel_we        = laser_we[i];
        sel_coords    = laser_coords[15*i +: 15];
        sel_colour    = laser_colour[9*i +: 9];
        sel_destroyed = laser_destroyed[4*i +: 4];
      end
    end
  end

`ifdef LASER_SCHED_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] wd_cnt_q;
  logic             timeout_err_q;

  // A genuine done in the same cycle as the limit wins over the abort.
  assign abort_d = (state_q == S_BUSY) && !sel_done &&
                   (wd_cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == S_START) begin
        wd_cnt_q <= '0;
      end else if (state_q == S_BUSY) begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
      if (abort_d) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign timeout_err = timeout_err_q;
`else
  assign abort_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      rr_ptr_q      <= '0;
      scanned_q     <= '0;
      acc_q         <= '0;
      enable_draw_q <= '0;
      destroyed_q   <= '0;
      cycle_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      enable_draw_q <= '0;
      cycle_done_q  <= 1'b0;

      // Only IDLE accepts a frame; anything else (including DONE) is an overrun.
      if (frame_start && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            state_q   <= S_SCAN;
            idx_q     <= rr_ptr_q;
            scanned_q <= '0;
            acc_q     <= '0;
          end
        end

        S_SCAN: begin
          if (sel_active) begin
            // Registered so the pulse is visible exactly during START.
            enable_draw_q <= idx_oh;
            state_q       <= S_START;
          end else begin
            idx_q     <= idx_inc_d;
            scanned_q <= scanned_inc_d;
            state_q   <= last_d ? S_DONE : S_SCAN;
          end
        end

        S_START: begin
          state_q <= S_BUSY;
        end

        S_BUSY: begin
          if (!abort_d) begin
            acc_q <= acc_q | sel_destroyed;
          end
          if (sel_done || abort_d) begin
            idx_q     <= idx_inc_d;
            scanned_q <= scanned_inc_d;
            state_q   <= last_d ? S_DONE : S_SCAN;
          end
        end

        S_DONE: begin
          cycle_done_q <= 1'b1;
          destroyed_q  <= acc_q;
          rr_ptr_q     <= rr_inc_d;
          state_q      <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign enable_draw    = enable_draw_q;
  assign cycle_done     = cycle_done_q;
  assign destroyed_cars = destroyed_q;
  assign frame_overrun  = overrun_q;
  assign busy           = (state_q != S_IDLE);

  // The VGA port is driven only while a laser owns it.
  assign vga_WriteEn = (state_q == S_BUSY) && sel_we;
  assign vga_coords  = (state_q == S_BUSY) ? sel_coords : 15'd0;
  assign vga_colour  = (state_q == S_BUSY) ? sel_colour : 9'd0;

endmodule

// File: tb/tb_laser_scheduler.sv
module tb_laser_scheduler;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           resetn;
  logic           frame_start;
  logic [N-1:0]   laser_active;
  logic [N-1:0]   laser_done;
  logic [N-1:0]   laser_we;
  logic [15*N-1:0] laser_coords;
  logic [9*N-1:0] laser_colour;
  logic [4*N-1:0] laser_destroyed;
  logic [N-1:0]   enable_draw;
  logic           vga_WriteEn;
  logic [14:0]    vga_coords;
  logic [8:0]     vga_colour;
  logic [3:0]     destroyed_cars;
  logic           cycle_done;
  logic           busy;
  logic           frame_overrun;
`ifdef LASER_SCHED_TIMEOUT_EN
  logic           timeout_err;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference state: round-robin start pointer and sticky overrun flag.
  int   rr_model  = 0;
  logic ovr_model = 1'b0;

  always #5 clk = ~clk;

  laser_scheduler #(
    .N_LASERS(N)
`ifdef LASER_SCHED_TIMEOUT_EN
    ,
    .TIMEOUT(40)
`endif
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .frame_start    (frame_start),
    .laser_active   (laser_active),
    .laser_done     (laser_done),
    .laser_we       (laser_we),
    .laser_coords   (laser_coords),
    .laser_colour   (laser_colour),
    .laser_destroyed(laser_destroyed),
    .enable_draw    (enable_draw),
    .vga_WriteEn    (vga_WriteEn),
    .vga_coords     (vga_coords),
    .vga_colour     (vga_colour),
    .destroyed_cars (destroyed_cars),
    .cycle_done     (cycle_done),
    .busy           (busy),
    .frame_overrun  (frame_overrun)
`ifdef LASER_SCHED_TIMEOUT_EN
    ,
    .timeout_err    (timeout_err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic drive_data();
    laser_we     = N'($urandom);
    laser_coords = (15*N)'({$urandom, $urandom});
    laser_colour = (9*N)'({$urandom, $urandom});
  endtask

  task automatic check_vga_sel(input int idx);
    check("vga_WriteEn_sel", 64'(vga_WriteEn), 64'(laser_we[idx]));
    check("vga_coords_sel",  64'(vga_coords),  64'(laser_coords[15*idx +: 15]));
    check("vga_colour_sel",  64'(vga_colour),  64'(laser_colour[9*idx +: 9]));
  endtask

  task automatic check_vga_idle();
    check("vga_WriteEn_idle", 64'(vga_WriteEn), 64'd0);
    check("vga_coords_idle",  64'(vga_coords),  64'd0);
    check("vga_colour_idle",  64'(vga_colour),  64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_enable_draw"},    64'(enable_draw),    64'd0);
    check({tag, "_vga_WriteEn"},    64'(vga_WriteEn),    64'd0);
    check({tag, "_vga_coords"},     64'(vga_coords),     64'd0);
    check({tag, "_vga_colour"},     64'(vga_colour),     64'd0);
    check({tag, "_destroyed_cars"}, 64'(destroyed_cars), 64'd0);
    check({tag, "_cycle_done"},     64'(cycle_done),     64'd0);
    check({tag, "_busy"},           64'(busy),           64'd0);
    check({tag, "_frame_overrun"},  64'(frame_overrun),  64'd0);
  endtask

  // One frame: the bench plays every laser, answering each start pulse with a
  // done after dly BUSY cycles. Expectations come from the round-robin rule:
  // visit order, OR of the active lasers' masks, and the cycle count
  // N + 2 + (#active)*(dly + 2) from the frame_start cycle to cycle_done.
  task automatic run_frame(input logic [N-1:0] act, input int dly,
                           input logic [4*N-1:0] dmask, input bit inject);
    int         order[$];
    int         pos;
    int         cyc;
    int         exp_cyc;
    int         idx;
    bit         seen_done;
    logic [3:0] exp_d;
    logic [N-1:0] oh;

    order = {};
    exp_d = 4'd0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (rr_model + k) % N;
      if (act[i]) begin
        order.push_back(i);
        exp_d = exp_d | dmask[4*i +: 4];
      end
    end
    exp_cyc = N + 2 + order.size() * (dly + 2);

    @(posedge clk); #1;
    laser_active    = act;
    laser_destroyed = dmask;
    laser_done      = '0;
    frame_start     = 1'b1;
    drive_data();
    cyc       = 0;
    pos       = 0;
    seen_done = 1'b0;

    while (cyc < 3000) begin
      @(negedge clk);
      if (cycle_done) begin
        seen_done = 1'b1;
        break;
      end
      if (enable_draw != '0) begin
        idx = 0;
        for (int i = N - 1; i >= 0; i--) if (enable_draw[i]) idx = i;
        if (pos < order.size()) begin
          check("enable_draw_order", 64'(enable_draw), 64'(onehot(order[pos])));
        end else begin
          check("enable_draw_extra", 64'(enable_draw), 64'd0);
        end
        oh = onehot(idx);
        for (int c = 0; c <= dly; c++) begin
          @(posedge clk); #1;
          frame_start  = inject && (c == 0);
          laser_active = N'($urandom);  // must not matter while BUSY
          drive_data();
          laser_done   = N'($urandom) & ~oh;
          if (c == dly) laser_done = laser_done | oh;
          cyc++;
          @(negedge clk);
          check_vga_sel(idx);
          check("enable_draw_width", 64'(enable_draw), 64'd0);
          check("busy_in_service", 64'(busy), 64'd1);
        end
        if (inject) ovr_model = 1'b1;
        pos++;
      end else begin
        check_vga_idle();
      end
      @(posedge clk); #1;
      frame_start  = 1'b0;
      laser_done   = '0;
      laser_active = act;
      drive_data();
      cyc++;
    end

    check("cycle_done_seen", 64'(seen_done), 64'd1);
    check("frame_latency", 64'(cyc), 64'(exp_cyc));
    check("lasers_serviced", 64'(pos), 64'(order.size()));
    check("destroyed_cars", 64'(destroyed_cars), 64'(exp_d));
    check("busy_at_cycle_done", 64'(busy), 64'd0);
    check_vga_idle();
    @(posedge clk); #1;
    @(negedge clk);
    check("cycle_done_width", 64'(cycle_done), 64'd0);
    check("destroyed_hold", 64'(destroyed_cars), 64'(exp_d));
    check("frame_overrun", 64'(frame_overrun), 64'(ovr_model));
    rr_model = (rr_model + 1) % N;
    $display("frame act=%b dly=%0d rr_next=%0d lasers=%0d cycles=%0d destroyed=%b overrun=%b",
             act, dly, rr_model, pos, cyc, destroyed_cars, frame_overrun);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit got;

    resetn          = 1'b0;
    frame_start     = 1'b0;
    laser_active    = '0;
    laser_done      = '0;
    laser_destroyed = '0;
    drive_data();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;

    // All lasers idle: pure scan, cycle_done at N+2.
    run_frame(4'b0000, 0, 16'hFFFF, 1'b0);

    // Two towers, three frames to exercise the rotating start pointer.
    run_frame(4'b1010, 20, 16'h8421, 1'b0);
    run_frame(4'b1010, 20, 16'h1248, 1'b0);
    run_frame(4'b1010, 20, 16'h3C5A, 1'b0);

    // Masks of inactive lasers (1 and 3) must not reach the result.
    run_frame(4'b0101, 3, {4'b1111, 4'b0100, 4'b1010, 4'b0001}, 1'b0);

    // frame_start while servicing is ignored and flagged.
    run_frame(4'b0110, 4, 16'h0F30, 1'b1);

    for (int f = 0; f < 8; f++) begin
      run_frame(N'($urandom), int'($urandom_range(0, 6)), 16'($urandom), 1'b0);
    end

    // Asynchronous reset while a laser owns the VGA port.
    @(posedge clk); #1;
    laser_active    = 4'b0100;
    laser_destroyed = 16'h0700;
    frame_start     = 1'b1;
    got             = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      @(negedge clk);
      if (enable_draw != '0) begin
        got = 1'b1;
        break;
      end
    end
    check("reset_setup_enable", 64'(got), 64'd1);
    @(posedge clk); #1;
    laser_we = '1;
    @(negedge clk);
    check("busy_before_reset", 64'(busy), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check_all_zero("midbusy_reset");
    @(posedge clk); #1;
    check_all_zero("midbusy_reset_edge");
    @(negedge clk);
    resetn    = 1'b1;
    rr_model  = 0;
    ovr_model = 1'b0;
    $display("reset applied mid-service, outputs checked");

    // Pointer restarts at laser 0 after reset.
    run_frame(4'b1111, 2, 16'h1111, 1'b0);

`ifdef LASER_SCHED_TIMEOUT_EN
    // A laser that never answers is abandoned; the frame still completes.
    @(posedge clk); #1;
    laser_active = 4'b0001;
    laser_done   = '0;
    frame_start  = 1'b1;
    got          = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      @(negedge clk);
      if (cycle_done) begin
        got = 1'b1;
        break;
      end
    end
    check("timeout_cycle_done", 64'(got), 64'd1);
    check("timeout_err", 64'(timeout_err), 64'd1);
    rr_model = (rr_model + 1) % N;
    $display("watchdog frame done=%b timeout_err=%b", got, timeout_err);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
